alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Arbitrated front end for the shared 16-bit add/subtract datapath. Two independent requesters issue operand pairs plus an opcode over valid/ready handshakes. A round-robin arbiter grants one request at a time, registers the operands, and computes the result on the clocked stage. The result is returned on a single tagged response channel. The block sits between the top-level operand sources and the arithmetic units, and replaces direct wiring of the a/b inputs.

## Interface
- WIDTH, 16, operand/result width
- CNT_WIDTH, 16, width of completed-operation counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req0_valid / req1_valid  input  1  requester N has a request
- req0_ready / req1_ready  output  1  request N accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- req0_op / req1_op  input  1  0 = add (a+b), 1 = sub (a-b)
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns the result
- rsp_data  output  WIDTH  result, modulo 2^WIDTH
- rsp_flag  output  1  carry-out for add, borrow for sub (a<b unsigned)
- busy  output  1  state != IDLE
- done_count  output  CNT_WIDTH  completed responses, wraps

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the arbiter picks a grant from the current valid requests. Only that requester sees ready=1. On the valid&ready edge, latch a, b, op and id, then go to EXEC. With no valid request, stay in IDLE.
- EXEC: one cycle. Compute the WIDTH+1-bit sum or difference into the result register, then go to RESP unconditionally.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_flag are held stable until rsp_valid&rsp_ready. On that edge: go to IDLE, set last_grant to rsp_id, and increment done_count.
- Round-robin rules:
  - If both requests are valid, grant the requester that is not last_grant.
  - If one request is valid, grant it regardless of last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Both req*_ready are 0 in EXEC and RESP, and while rst_n=0.
- A requester may drop valid before it is granted. The grant is recomputed every cycle in IDLE, so a dropped request is never accepted.
- Arithmetic:
  - Add: rsp_data = (a+b)[WIDTH-1:0]; rsp_flag = (a+b)[WIDTH].
  - Sub: rsp_data = (a-b) mod 2^WIDTH; rsp_flag = (a<b) unsigned.
- done_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, last_grant=1.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flag=0.
  - busy=0, done_count=0.
  - Any in-flight operation is discarded with no response. This holds for reset in EXEC or in RESP.
- Latency: accept edge at cycle N, rsp_valid high from cycle N+2. With rsp_ready held high, the response handshakes at the end of cycle N+2.
- Throughput: at most one operation per 3 cycles. A new accept is possible in the cycle after the response handshake.
- Back-pressure: rsp_ready=0 holds RESP indefinitely. Response outputs and done_count stay frozen.
- A request that arrives during busy is not lost. Its valid must stay high, and it is eligible in the first IDLE cycle.
- Simultaneous events:
  - A response handshake and a new valid request in the same cycle: the request waits one cycle, because readiness exists only in IDLE.
  - On the accept edge, the grant reflects last_grant as updated by the preceding response.

## Structure
- Shared package alu_share_pkg:
  - state_e (IDLE, EXEC, RESP)
  - op_e (OP_ADD=0, OP_SUB=1)
  - localparam REQ_NUM=2
- Sub-module rr_arbiter2:
  - Combinational two-way round-robin grant.
  - Inputs: valid[1:0], last_grant, enable.
  - Outputs: one-hot grant[1:0].
  - It is instantiated once. The top FSM owns last_grant.
- The arithmetic uses a single WIDTH+1-bit adder with the b operand inverted plus carry-in for sub.

## Test plan
- Reset, then req0 valid with a=0x0003, b=0x0004, add, rsp_ready=1 → req0_ready high in the first cycle; rsp_valid two cycles after accept; rsp_id=0, rsp_data=0x0007, rsp_flag=0; done_count=1.
- req1 sub with a=0x0002, b=0x0005 → rsp_data=0xFFFD, rsp_flag=1, rsp_id=1. Add with a=0xFFFF, b=0x0001 → rsp_data=0x0000, rsp_flag=1.
- Both requesters valid continuously for 4 operations → grant order 0,1,0,1 and done_count=4. req1 alone after a grant to req1 → req1 granted again.
- Response held with rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, both req*_ready=0, done_count unchanged; release → completes in 1 cycle.
- rst_n driven low in EXEC, then again in RESP, for one cycle each → next cycle rsp_valid=0 and busy=0, done_count=0, and the next tie is granted to requester 0.
- done_count preset by 2^CNT_WIDTH completions (or CNT_WIDTH=4 with 16 operations) → wraps to 0.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared types for the arbitrated add/subtract front end.
package alu_share_pkg;

    localparam int REQ_NUM = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/alu_share_if.sv
// Request/response bundle between the two operand sources, the arbiter and the result consumer.
interface alu_share_if #(parameter int WIDTH = 16) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_flag;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_flag
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_flag
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; a tie goes to the requester that was not served last.
module rr_arbiter2
    import alu_share_pkg::*;
(
    input  logic [REQ_NUM-1:0] valid,
    input  logic               last_grant,
    input  logic               enable,
    output logic [REQ_NUM-1:0] grant
);

    // one-hot grant from the current valid pattern
    always_comb begin
        grant = 2'b00;
        if (!enable) begin
            grant = 2'b00;
        end else begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrated front end of the shared add/subtract datapath: grant, execute, then hold a
// tagged response until the consumer takes it.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_if.slave           bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_count
);

    // Single adder: subtract is a + ~b + 1, and the borrow is the inverted carry-out.
    function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input op_e          op);
        logic [WIDTH:0] sum;
        logic           is_sub;
        is_sub = (op == OP_SUB);
        sum    = {1'b0, a} + {1'b0, (is_sub ? ~b : b)} + {{WIDTH{1'b0}}, is_sub};
        return {(is_sub ? ~sum[WIDTH] : sum[WIDTH]), sum[WIDTH-1:0]};
    endfunction

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    op_e                  op_q, op_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                 rsp_flag_q, rsp_flag_d;
    logic [CNT_WIDTH-1:0] done_count_q, done_count_d;
    logic [1:0]           grant_s;
    logic [WIDTH:0]       calc_s;

    rr_arbiter2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_q),
        .enable     ((state_q == IDLE) && rst_n),
        .grant      (grant_s)
    );

    assign calc_s         = add_sub(a_q, b_q, op_q);
    assign bus.req0_ready = grant_s[0];
    assign bus.req1_ready = grant_s[1];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_flag   = rsp_flag_q;
    assign busy           = (state_q != IDLE);
    assign done_count     = done_count_q;

    // next-state and datapath register updates
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_flag_d   = rsp_flag_q;
        done_count_d = done_count_q;
        case (state_q)
            IDLE: begin
                if (grant_s[0]) begin
                    a_d      = bus.req0_a;
                    b_d      = bus.req0_b;
                    op_d     = op_e'(bus.req0_op);
                    rsp_id_d = 1'b0;
                    state_d  = EXEC;
                end else if (grant_s[1]) begin
                    a_d      = bus.req1_a;
                    b_d      = bus.req1_b;
                    op_d     = op_e'(bus.req1_op);
                    rsp_id_d = 1'b1;
                    state_d  = EXEC;
                end else begin
                    state_d  = IDLE;
                end
            end
            EXEC: begin
                rsp_data_d  = calc_s[WIDTH-1:0];
                rsp_flag_d  = calc_s[WIDTH];
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    done_count_d = done_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d      = IDLE;
                end else begin
                    state_d      = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // state registers; reset drops any in-flight operation without a response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            op_q         <= OP_ADD;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= {WIDTH{1'b0}};
            rsp_flag_q   <= 1'b0;
            done_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flag_q   <= rsp_flag_d;
            done_count_q <= done_count_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, corner sequences and
// randomized traffic against a behavioural model.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int W  = 16;
    localparam int CW = 4;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] exp_data;
        logic        exp_flag;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy;
    logic [CW-1:0] done_count;

    alu_share_if #(.WIDTH(W)) bus ();

    alu_share_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_last = 1;
    int m_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Reference arithmetic straight from the add/sub definition.
    function automatic logic [16:0] ref_calc(input logic [15:0] a, input logic [15:0] b, input logic op);
        int unsigned av, bv, r;
        av = a;
        bv = b;
        if (op == 1'b0) begin
            r = av + bv;
            return {(r > 32'd65535), r[15:0]};
        end
        r = (av + 32'd65536 - bv) % 32'd65536;
        return {(av < bv), r[15:0]};
    endfunction

    // Caller presents the request(s) during an IDLE cycle; the grant must be immediate.
    task automatic do_txn(input int hold, input int exp_id, input logic [15:0] exp_data,
                          input logic exp_flag, input string name);
        settle();
        chk({name, "_ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, (exp_id == 0) ? 32'd1 : 32'd2);
        if (!(bus.req0_ready || bus.req1_ready)) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            return;
        end
        next_cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        settle();
        chk({name, "_exec"}, {30'd0, bus.rsp_valid, busy}, 32'd1);
        next_cyc();
        bus.rsp_ready = (hold == 0);
        settle();
        chk({name, "_rsp"}, {13'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_flag, bus.rsp_data},
            {13'd0, 1'b1, exp_id[0], exp_flag, exp_data});
        for (int h = 0; h < hold; h++) begin
            next_cyc();
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            bus.rsp_ready  = (h == hold - 1);
            settle();
            chk({name, "_held"},
                {7'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_flag, bus.rsp_data, bus.req0_ready, bus.req1_ready, done_count},
                {7'd0, 1'b1, exp_id[0], exp_flag, exp_data, 2'b00, m_cnt[CW-1:0]});
        end
        next_cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        m_cnt  = (m_cnt + 1) % 16;
        m_last = exp_id;
        settle();
        chk({name, "_done"}, {26'd0, busy, bus.rsp_valid, done_count}, {26'd0, 2'b00, m_cnt[CW-1:0]});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        int          grants[$];
        int          cycles;
        int          vm;
        int          eid;
        logic [16:0] r;
        logic [15:0] ra0, rb0, ra1, rb1;
        logic        rop0, rop1;

        vecs = '{
            '{0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0},
            '{1, 16'h0002, 16'h0005, 1'b1, 16'hFFFD, 1'b1},
            '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1},
            '{1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0},
            '{0, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1},
            '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1},
            '{0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0},
            '{1, 16'h1000, 16'h0FFF, 1'b1, 16'h0001, 1'b0},
            '{1, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0}
        };

        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_a = 16'h0; bus.req0_b = 16'h0; bus.req0_op = 1'b0;
        bus.req1_a = 16'h0; bus.req1_b = 16'h0; bus.req1_op = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) next_cyc();
        settle();
        chk("reset_state",
            {10'd0, bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_flag, busy, bus.rsp_data, done_count},
            32'd0);
        next_cyc();
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;

        // directed vector table, one requester at a time
        foreach (vecs[i]) begin
            if (vecs[i].id == 0) begin
                bus.req0_a = vecs[i].a; bus.req0_b = vecs[i].b; bus.req0_op = vecs[i].op;
                bus.req0_valid = 1'b1;
            end else begin
                bus.req1_a = vecs[i].a; bus.req1_b = vecs[i].b; bus.req1_op = vecs[i].op;
                bus.req1_valid = 1'b1;
            end
            do_txn(0, vecs[i].id, vecs[i].exp_data, vecs[i].exp_flag, $sformatf("vec%0d", i));
        end

        // back-pressure: response held 5 cycles
        bus.req0_a = 16'h00AA; bus.req0_b = 16'h0055; bus.req0_op = 1'b0;
        bus.req0_valid = 1'b1;
        do_txn(5, 0, 16'h00FF, 1'b0, "backpressure");

        // reset while in EXEC
        bus.req0_a = 16'h0011; bus.req0_b = 16'h0022; bus.req0_op = 1'b0;
        bus.req0_valid = 1'b1;
        next_cyc();
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        settle();
        chk("reset_exec", {16'd0, bus.rsp_valid, busy, bus.rsp_flag, bus.rsp_id, done_count, 8'd0}, 32'd0);
        next_cyc();
        next_cyc();
        settle();
        chk("reset_exec_no_rsp", {30'd0, bus.rsp_valid, busy}, 32'd0);

        // reset while in RESP, with a completed op counted first
        bus.req1_a = 16'h0007; bus.req1_b = 16'h0001; bus.req1_op = 1'b1;
        bus.req1_valid = 1'b1;
        m_cnt = 0; m_last = 1;
        do_txn(0, 1, 16'h0006, 1'b0, "pre_reset");
        bus.req1_valid = 1'b1;
        next_cyc();
        bus.req1_valid = 1'b0;
        next_cyc();
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        m_cnt = 0; m_last = 1;
        settle();
        chk("reset_resp", {16'd0, bus.rsp_valid, busy, bus.rsp_flag, bus.rsp_id, done_count, 8'd0}, 32'd0);

        // both requesters held valid: alternating grants starting with requester 0
        bus.req0_a = 16'h0001; bus.req0_b = 16'h0002; bus.req0_op = 1'b0;
        bus.req1_a = 16'h000A; bus.req1_b = 16'h0003; bus.req1_op = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        cycles = 0;
        while (grants.size() < 4 && cycles < 40) begin
            settle();
            if (bus.req0_ready && bus.req1_ready) chk("tie_onehot", 32'd1, 32'd0);
            if (bus.req0_ready) grants.push_back(0);
            else if (bus.req1_ready) grants.push_back(1);
            if (bus.rsp_valid && grants.size() > 0)
                chk("tie_rsp_data", {15'd0, bus.rsp_id, bus.rsp_data},
                    (grants[$] == 0) ? 32'h0000_0003 : 32'h0001_0007);
            next_cyc();
            cycles++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("tie_grant_count", grants.size(), 32'd4);
        for (int i = 0; i < grants.size(); i++) chk($sformatf("tie_order%0d", i), grants[i], i % 2);
        next_cyc();
        next_cyc();
        bus.rsp_ready = 1'b0;
        settle();
        m_cnt = 4; m_last = 1;
        chk("tie_done_count", {28'd0, done_count}, 32'd4);

        // randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            vm   = $urandom_range(1, 3);
            ra0  = 16'($urandom); rb0 = 16'($urandom); rop0 = 1'($urandom);
            ra1  = 16'($urandom); rb1 = 16'($urandom); rop1 = 1'($urandom);
            if (vm == 3) eid = 1 - m_last;
            else if (vm == 1) eid = 0;
            else eid = 1;
            r = (eid == 0) ? ref_calc(ra0, rb0, rop0) : ref_calc(ra1, rb1, rop1);
            bus.req0_a = ra0; bus.req0_b = rb0; bus.req0_op = rop0;
            bus.req1_a = ra1; bus.req1_b = rb1; bus.req1_op = rop1;
            bus.req0_valid = vm[0];
            bus.req1_valid = vm[1];
            do_txn($urandom_range(0, 3), eid, r[15:0], r[16], $sformatf("rnd%0d", k));
        end

        // run on until the 4-bit counter wraps to zero
        cycles = 0;
        while (m_cnt != 0 && cycles < 20) begin
            bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_op = 1'b0;
            bus.req0_valid = 1'b1;
            do_txn(0, 0, 16'h0002, 1'b0, "wrap_fill");
            cycles++;
        end
        chk("count_wrap", {28'd0, done_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
